stream_unpacker: RTL and testbench

- AXI4-Stream video sink. Accepts the 32-bit packed RGB stream (4 pixels in 3 words, tuser = start of frame, tlast = end of line) produced by the team's pixel packer.
- Unpacks the stream into one 24-bit pixel per cycle with x/y coordinates and sof/eol flags.
- Checks frame and line framing and raises sticky error flags.
- Sits between the video DMA/loopback path and the pixel-processing blocks; also serves as the bench-side checker for pattern streamers.

---
 rtl/stream_unpacker.sv | 174 +++++++++++++++++
 tb/tb_stream_unpacker.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_unpacker.sv
// AXI4-Stream video sink: unpacks 4 RGB pixels carried in 3 32-bit words into one
// 24-bit pixel per cycle with x/y coordinates, sof/eol flags and sticky framing errors.
module stream_unpacker #(
   parameter int X_SIZE = 640,
   parameter int Y_SIZE = 480
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] in_stream_tdata,
   input  logic [3:0]  in_stream_tkeep,
   input  logic        in_stream_tlast,
   input  logic        in_stream_tuser,
   input  logic        in_stream_tvalid,
   output logic        in_stream_tready,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        sof_err,
   output logic        line_err,
   input  logic        err_clear
);

   localparam logic [9:0] X_LAST  = 10'(X_SIZE - 1);
   localparam logic [9:0] X_TLAST = 10'(X_SIZE - 2);
   localparam logic [8:0] Y_LAST  = 9'(Y_SIZE - 1);

   typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

   phase_t      phase, phase_next, eff_phase;
   logic [23:0] residue, residue_next;
   logic [9:0]  x_cnt, x_next, emit_x;
   logic [8:0]  y_cnt, y_next, emit_y;
   logic        eol_pending, eol_pending_next;
   logic        slot_free, accept, emit;
   logic [23:0] emit_rgb;
   logic        force_eol, emit_eol, tlast_expected;
   logic        sof_err_set, line_err_set;
   logic        unused_tkeep;

   assign unused_tkeep     = ^in_stream_tkeep;
   assign slot_free        = !pix_valid || pix_ready;
   assign in_stream_tready = aresetn && slot_free && (phase != P3);
   assign accept           = in_stream_tvalid && in_stream_tready;

   always_ff @(posedge aclk) begin
      if (!aresetn) phase <= P0;
      else          phase <= phase_next;
   end

   // A tuser word is always decoded as W0 at (0,0); P3 drains the residue without consuming a word.
   always_comb begin
      phase_next       = phase;
      residue_next     = residue;
      eol_pending_next = eol_pending;
      eff_phase        = phase;
      emit             = 1'b0;
      emit_rgb         = 24'h0;
      emit_x           = x_cnt;
      emit_y           = y_cnt;
      force_eol        = 1'b0;
      tlast_expected   = 1'b0;
      sof_err_set      = 1'b0;
      line_err_set     = 1'b0;
      x_next           = x_cnt;
      y_next           = y_cnt;
      emit_eol         = 1'b0;
      if (accept) begin
         emit = 1'b1;
         if (in_stream_tuser) begin
            eff_phase   = P0;
            emit_x      = '0;
            emit_y      = '0;
            sof_err_set = (phase != P0) || (x_cnt != '0) || (y_cnt != '0);
         end else begin
            sof_err_set = (phase == P0) && (x_cnt == '0) && (y_cnt == '0);
         end
         case (eff_phase)
            P0: begin
               emit_rgb     = {in_stream_tdata[7:0], in_stream_tdata[15:8], in_stream_tdata[23:16]};
               residue_next = {16'h0, in_stream_tdata[31:24]};
               phase_next   = P1;
            end
            P1: begin
               emit_rgb     = {residue[7:0], in_stream_tdata[7:0], in_stream_tdata[15:8]};
               residue_next = {8'h0, in_stream_tdata[31:16]};
               phase_next   = P2;
            end
            P2: begin
               emit_rgb     = {residue[7:0], residue[15:8], in_stream_tdata[7:0]};
               residue_next = in_stream_tdata[31:8];
               phase_next   = P3;
            end
            default: begin
            end
         endcase
         // An early tlast on W2 still owns p3, so its line end is deferred to the P3 emission.
         tlast_expected = (eff_phase == P2) && (emit_x == X_TLAST);
         if (tlast_expected && !in_stream_tlast) line_err_set = 1'b1;
         if (in_stream_tlast && !tlast_expected) begin
            line_err_set = 1'b1;
            if (eff_phase == P2) begin
               eol_pending_next = 1'b1;
            end else begin
               force_eol    = 1'b1;
               residue_next = '0;
               phase_next   = P0;
            end
         end
      end else if (phase == P3 && slot_free) begin
         emit             = 1'b1;
         emit_rgb         = {residue[7:0], residue[15:8], residue[23:16]};
         residue_next     = '0;
         phase_next       = P0;
         force_eol        = eol_pending;
         eol_pending_next = 1'b0;
      end
      emit_eol = force_eol || (emit_x == X_LAST);
      if (emit) begin
         if (emit_eol) begin
            x_next = '0;
            y_next = (emit_y == Y_LAST) ? '0 : emit_y + 9'd1;
         end else begin
            x_next = emit_x + 10'd1;
            y_next = emit_y;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         residue     <= '0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         eol_pending <= 1'b0;
         pix_r       <= '0;
         pix_g       <= '0;
         pix_b       <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_sof     <= 1'b0;
         pix_eol     <= 1'b0;
         pix_valid   <= 1'b0;
         sof_err     <= 1'b0;
         line_err    <= 1'b0;
      end else begin
         residue     <= residue_next;
         x_cnt       <= x_next;
         y_cnt       <= y_next;
         eol_pending <= eol_pending_next;
         if (emit) begin
            pix_r     <= emit_rgb[23:16];
            pix_g     <= emit_rgb[15:8];
            pix_b     <= emit_rgb[7:0];
            pix_x     <= emit_x;
            pix_y     <= emit_y;
            pix_sof   <= (emit_x == '0) && (emit_y == '0);
            pix_eol   <= emit_eol;
            pix_valid <= 1'b1;
         end else if (pix_ready) begin
            pix_valid <= 1'b0;
         end
         // A new error in the same cycle as err_clear must survive.
         sof_err  <= sof_err_set  || (sof_err  && !err_clear);
         line_err <= line_err_set || (line_err && !err_clear);
      end
   end

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed self-checking bench for stream_unpacker: packing, full frame, backpressure,
// framing errors and mid-group reset, using a small 16x8 frame.
module tb_stream_unpacker;

   localparam int XS  = 16;
   localparam int YS  = 8;
   localparam int WPL = XS * 3 / 4;

   typedef struct packed {
      logic [23:0] rgb;
      logic [9:0]  x;
      logic [8:0]  y;
      logic        sof;
      logic        eol;
   } pix_t;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        user;
   } word_t;

   logic        aclk;
   logic        aresetn;
   logic [31:0] in_stream_tdata;
   logic [3:0]  in_stream_tkeep;
   logic        in_stream_tlast;
   logic        in_stream_tuser;
   logic        in_stream_tvalid;
   logic        in_stream_tready;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic        pix_sof, pix_eol, pix_valid, pix_ready;
   logic        sof_err, line_err, err_clear;

   stream_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
      .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
      .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
      .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .sof_err(sof_err), .line_err(line_err), .err_clear(err_clear)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   word_t word_q[$];
   pix_t  exp_q[$];
   pix_t  got_q[$];
   int    got_cyc_q[$];
   int    cyc_cnt = 0, pix_since_rst = 0, stall_viol = 0, p3_viol = 0;
   int    words_acc = 0, hs_tready = 0;
   bit    stalled_prev = 1'b0;
   pix_t  held;
   int    run_base, stall_base, p3_base, words_base, tready_base;

   function automatic pix_t curPix();
      return {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
   endfunction

   // Observes handshakes half a cycle away from the active edge.
   always @(negedge aclk) begin
      cyc_cnt++;
      if (!aresetn) begin
         pix_since_rst = 0;
         stalled_prev  = 1'b0;
      end else begin
         if (stalled_prev && (!pix_valid || curPix() != held)) stall_viol++;
         stalled_prev = pix_valid && !pix_ready;
         held = curPix();
         if (in_stream_tvalid && in_stream_tready) begin
            words_acc++;
            if (((pix_since_rst + int'(pix_valid)) % 4) == 3) p3_viol++;
         end
         if (pix_valid && pix_ready) begin
            got_q.push_back(curPix());
            got_cyc_q.push_back(cyc_cnt);
            pix_since_rst++;
            if (in_stream_tready) hs_tready++;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [23:0] pixVal(input int mode, input int x, input int y);
      logic [7:0] r, g, b;
      if (mode == 0) return 24'h008080;
      r = 8'(x * 7 + y * 3 + 1);
      g = 8'(x * 16 + y);
      b = 8'(200 - x - 5 * y);
      return {r, g, b};
   endfunction

   // Packs one line into words (little-endian byte stream r,g,b,...) and records the pixels it should yield.
   task automatic addLine(input int y, input int mode, input int n_words, input bit first_user,
                          input bit last_ok, input bit early);
      logic [7:0]  b [0:XS*3-1];
      logic [23:0] v;
      int          npix;
      for (int x = 0; x < XS; x++) begin
         v = pixVal(mode, x, y);
         b[3*x] = v[23:16]; b[3*x+1] = v[15:8]; b[3*x+2] = v[7:0];
      end
      for (int k = 0; k < n_words; k++) begin
         word_t w;
         w.data = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
         w.user = first_user && (k == 0);
         w.last = (last_ok && k == WPL - 1) || (early && k == n_words - 1);
         word_q.push_back(w);
      end
      npix = (4 * n_words) / 3;
      for (int x = 0; x < npix; x++) begin
         pix_t p;
         p.rgb = pixVal(mode, x, y);
         p.x   = 10'(x);
         p.y   = 9'(y);
         p.sof = (x == 0) && (y == 0);
         p.eol = (x == XS - 1) || (early && x == npix - 1);
         exp_q.push_back(p);
      end
   endtask

   task automatic startRun();
      exp_q.delete();
      word_q.delete();
      run_base    = got_q.size();
      stall_base  = stall_viol;
      p3_base     = p3_viol;
      words_base  = words_acc;
      tready_base = hs_tready;
   endtask

   task automatic applyReset();
      aresetn = 1'b0; in_stream_tvalid = 1'b0; in_stream_tuser = 1'b0; in_stream_tlast = 1'b0;
      pix_ready = 1'b1; err_clear = 1'b0;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
   endtask

   task automatic pulseClear();
      err_clear = 1'b1;
      @(posedge aclk); #1;
      err_clear = 1'b0;
   endtask

   task automatic applyStimulus(input bit throttle, input int n_pix);
      int cyc  = 0;
      bit acc  = 1'b0;
      bit hold = 1'b0;
      while ((word_q.size() > 0 || (got_q.size() - run_base) < n_pix) && cyc < 3000) begin
         if (word_q.size() > 0 && (hold || !throttle || $urandom_range(1, 0) == 1)) begin
            in_stream_tvalid = 1'b1;
            in_stream_tdata  = word_q[0].data;
            in_stream_tlast  = word_q[0].last;
            in_stream_tuser  = word_q[0].user;
         end else begin
            in_stream_tvalid = 1'b0; in_stream_tlast = 1'b0; in_stream_tuser = 1'b0;
         end
         pix_ready = throttle ? 1'($urandom_range(1, 0)) : 1'b1;
         @(negedge aclk);
         acc  = in_stream_tvalid && in_stream_tready;
         hold = in_stream_tvalid && !acc;
         @(posedge aclk); #1;
         if (acc) void'(word_q.pop_front());
         cyc++;
      end
      in_stream_tvalid = 1'b0; in_stream_tlast = 1'b0; in_stream_tuser = 1'b0; pix_ready = 1'b1;
      checkOutput("stream_within_budget", 64'(cyc < 3000), 64'd1);
   endtask

   task automatic comparePixels(input string tag);
      int mism = 0;
      checkOutput({tag, "_pix_count"}, 64'(got_q.size() - run_base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (run_base + i >= got_q.size() || got_q[run_base + i] !== exp_q[i]) begin
            if (mism == 0 && run_base + i < got_q.size())
               $display("[TB] %s first differing pixel %0d got %h want %h", tag, i, got_q[run_base + i], exp_q[i]);
            mism++;
         end
      end
      checkOutput({tag, "_pix_data"}, 64'(mism), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int eol_cnt, sof_cnt, n;
      aresetn = 1'b0; in_stream_tkeep = 4'hF; in_stream_tdata = 32'hDEADBEEF;
      in_stream_tvalid = 1'b1; in_stream_tuser = 1'b1; in_stream_tlast = 1'b0;
      pix_ready = 1'b1; err_clear = 1'b0;

      // Reset state, with a word offered that must not be taken
      repeat (3) @(posedge aclk); #1;
      checkOutput("rst_tready", 64'(in_stream_tready), 64'd0);
      checkOutput("rst_outputs", 64'({pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, sof_err, line_err}), 64'd0);
      in_stream_tvalid = 1'b0; in_stream_tuser = 1'b0; aresetn = 1'b1;
      #1 checkOutput("post_rst_tready", 64'(in_stream_tready), 64'd1);

      // Packing, cycle by cycle: 1-cycle latency and no word taken in P3
      @(posedge aclk); #1;
      in_stream_tvalid = 1'b1; in_stream_tuser = 1'b1; in_stream_tdata = 32'h04030201;
      @(negedge aclk) checkOutput("pack_w0_tready", 64'(in_stream_tready), 64'd1);
      @(posedge aclk); #1;
      in_stream_tuser = 1'b0; in_stream_tdata = 32'h08070605;
      checkOutput("pack_p0", 64'({pix_valid, curPix()}), 64'({1'b1, 24'h010203, 10'd0, 9'd0, 1'b1, 1'b0}));
      @(posedge aclk); #1;
      in_stream_tdata = 32'h0C0B0A09;
      checkOutput("pack_p1", 64'({pix_valid, curPix()}), 64'({1'b1, 24'h040506, 10'd1, 9'd0, 1'b0, 1'b0}));
      @(posedge aclk); #1;
      in_stream_tvalid = 1'b0;
      checkOutput("pack_p2", 64'({pix_valid, curPix()}), 64'({1'b1, 24'h070809, 10'd2, 9'd0, 1'b0, 1'b0}));
      checkOutput("pack_p3_phase_tready", 64'(in_stream_tready), 64'd0);
      @(posedge aclk); #1;
      checkOutput("pack_p3", 64'({pix_valid, curPix()}), 64'({1'b1, 24'h0A0B0C, 10'd3, 9'd0, 1'b0, 1'b0}));
      checkOutput("pack_after_p3_tready", 64'(in_stream_tready), 64'd1);
      checkOutput("pack_errors", 64'({sof_err, line_err}), 64'd0);
      @(posedge aclk); #1;
      checkOutput("pack_idle_valid", 64'(pix_valid), 64'd0);

      // Reset after W1: the next group must decode cleanly with no stale residue
      applyReset();
      @(posedge aclk); #1;
      in_stream_tvalid = 1'b1; in_stream_tuser = 1'b1; in_stream_tdata = 32'h11223344;
      @(posedge aclk); #1;
      in_stream_tuser = 1'b0; in_stream_tdata = 32'h55667788;
      @(posedge aclk); #1;
      in_stream_tvalid = 1'b0; aresetn = 1'b0;
      repeat (2) @(posedge aclk); #1;
      checkOutput("rst_mid_clear", 64'({pix_valid, pix_r, pix_g, pix_b, in_stream_tready}), 64'd0);
      aresetn = 1'b1;
      startRun();
      addLine(0, 1, 3, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 4);
      comparePixels("rst_mid");
      checkOutput("rst_mid_errors", 64'({sof_err, line_err}), 64'd0);

      // Full frame plus the first group of the next frame, unthrottled
      applyReset();
      startRun();
      for (int y = 0; y < YS; y++) addLine(y, 0, WPL, (y == 0), 1'b1, 1'b0);
      addLine(0, 0, 3, 1'b1, 1'b0, 1'b0);
      n = YS * XS + 4;
      applyStimulus(1'b0, n);
      comparePixels("frame");
      eol_cnt = 0; sof_cnt = 0;
      for (int i = run_base; i < got_q.size(); i++) begin
         if (got_q[i].eol) eol_cnt++;
         if (got_q[i].sof) sof_cnt++;
      end
      checkOutput("frame_eol_count", 64'(eol_cnt), 64'(YS));
      checkOutput("frame_sof_count", 64'(sof_cnt), 64'd2);
      checkOutput("frame_words", 64'(words_acc - words_base), 64'(YS * WPL + 3));
      checkOutput("frame_tready_duty", 64'(hs_tready - tready_base), 64'(YS * WPL + 3));
      checkOutput("frame_one_pix_per_cycle", 64'(got_cyc_q[got_cyc_q.size() - 1] - got_cyc_q[run_base] + 1), 64'(n));
      checkOutput("frame_p3_accepts", 64'(p3_viol - p3_base), 64'd0);
      checkOutput("frame_errors", 64'({sof_err, line_err}), 64'd0);

      // Backpressure on both sides over two lines
      applyReset();
      startRun();
      addLine(0, 1, WPL, 1'b1, 1'b1, 1'b0);
      addLine(1, 1, WPL, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 2 * XS);
      comparePixels("bp");
      checkOutput("bp_stall_hold", 64'(stall_viol - stall_base), 64'd0);
      checkOutput("bp_p3_accepts", 64'(p3_viol - p3_base), 64'd0);
      checkOutput("bp_words", 64'(words_acc - words_base), 64'(2 * WPL));
      checkOutput("bp_errors", 64'({sof_err, line_err}), 64'd0);

      // Early tlast on word 10 (a W1): x=13 closes the line
      applyReset();
      startRun();
      addLine(0, 1, 11, 1'b1, 1'b0, 1'b1);
      addLine(1, 1, WPL, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 14 + XS);
      comparePixels("early");
      checkOutput("early_x13_eol", 64'({got_q[run_base + 13].x, got_q[run_base + 13].eol}), 64'({10'd13, 1'b1}));
      checkOutput("early_next_pos", 64'({got_q[run_base + 14].x, got_q[run_base + 14].y}), 64'({10'd0, 9'd1}));
      checkOutput("early_errors", 64'({sof_err, line_err}), 64'({1'b0, 1'b1}));
      pulseClear();
      checkOutput("early_cleared", 64'(line_err), 64'd0);

      // Mid-frame tuser at line 5, x=8
      applyReset();
      startRun();
      for (int y = 0; y < 5; y++) addLine(y, 1, WPL, (y == 0), 1'b1, 1'b0);
      addLine(5, 1, 6, 1'b0, 1'b0, 1'b0);
      addLine(0, 1, WPL, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 5 * XS + 8 + XS);
      comparePixels("resync");
      checkOutput("resync_pos", 64'({got_q[run_base + 88].x, got_q[run_base + 88].y, got_q[run_base + 88].sof}), 64'({10'd0, 9'd0, 1'b1}));
      checkOutput("resync_errors", 64'({sof_err, line_err}), 64'({1'b1, 1'b0}));
      pulseClear();
      checkOutput("resync_cleared", 64'(sof_err), 64'd0);

      // Frame without tuser and a line without tlast: both flagged, counters wrap normally
      applyReset();
      startRun();
      addLine(0, 1, WPL, 1'b0, 1'b0, 1'b0);
      addLine(1, 1, WPL, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 2 * XS);
      comparePixels("missing");
      checkOutput("missing_errors", 64'({sof_err, line_err}), 64'({1'b1, 1'b1}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
